// File: rtl/exact_match_lookup.sv
// rtl/exact_match_lookup.sv - exact-match key lookup: hash handshake plus linear probe of a key/value table
module exact_match_lookup #(
    parameter int ADDR_W    = 8,
    parameter int MAX_PROBE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [63:0]       req_key_i,
    output logic              req_ready_o,
    output logic              hash_start_o,
    output logic [63:0]       hash_key_o,
    input  logic              hash_ready_i,
    input  logic [31:0]       hash_val_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [96:0]       mem_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_hit_o,
    output logic [31:0]       resp_value_o,
    output logic [3:0]        resp_probes_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] H_ARM  = 3'd1;
    localparam logic [2:0] H_WAIT = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] CMP    = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]        state;
    logic [63:0]       key_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        probe_q;
    logic              start_q;
    logic              hit_q;
    logic [31:0]       value_q;
    logic [ADDR_W-1:0] probe_addr;
    logic              entry_valid;
    logic              key_match;
    logic              unused_hash_bits;

    // Addition is ADDR_W bits wide, so the probe index wraps naturally at the table end.
    assign probe_addr       = base_q + ADDR_W'(probe_q);
    assign entry_valid      = mem_data_i[96];
    assign key_match        = entry_valid && (mem_data_i[95:32] == key_q);
    assign unused_hash_bits = ^hash_val_i[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            probe_q <= '0;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
            value_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        key_q   <= req_key_i;
                        start_q <= 1'b1;
                        state   <= H_ARM;
                    end
                end
                H_ARM: begin
                    // A ready left high by the previous lookup is stale; wait for it to clear.
                    if (!hash_ready_i) begin
                        state <= H_WAIT;
                    end
                end
                H_WAIT: begin
                    if (hash_ready_i) begin
                        base_q  <= hash_val_i[ADDR_W-1:0];
                        probe_q <= '0;
                        start_q <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    addr_q  <= probe_addr;
                    probe_q <= probe_q + 4'd1;
                    state   <= CMP;
                end
                CMP: begin
                    if (key_match) begin
                        hit_q   <= 1'b1;
                        value_q <= mem_data_i[31:0];
                        state   <= RESP;
                    end else if (!entry_valid || (probe_q == 4'(MAX_PROBE))) begin
                        hit_q   <= 1'b0;
                        value_q <= '0;
                        state   <= RESP;
                    end else begin
                        state <= ISSUE;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst so an abort is visible in the very cycle reset is raised.
    assign req_ready_o   = rst || (state == IDLE);
    assign hash_start_o  = start_q && !rst;
    assign hash_key_o    = key_q;
    assign mem_rd_o      = (state == ISSUE) && !rst;
    assign mem_addr_o    = rst ? '0 : ((state == ISSUE) ? probe_addr : addr_q);
    assign resp_valid_o  = (state == RESP) && !rst;
    assign resp_hit_o    = hit_q;
    assign resp_value_o  = value_q;
    assign resp_probes_o = probe_q;

endmodule

// File: tb/tb_exact_match_lookup.sv
// tb/tb_exact_match_lookup.sv - directed self-checking bench for exact_match_lookup
module tb_exact_match_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [63:0] req_key_i;
    logic        req_ready_o;
    logic        hash_start_o;
    logic [63:0] hash_key_o;
    logic        hash_ready_i;
    logic [31:0] hash_val_i;
    logic        mem_rd_o;
    logic [7:0]  mem_addr_o;
    logic [96:0] mem_data_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_hit_o;
    logic [31:0] resp_value_o;
    logic [3:0]  resp_probes_o;

    always #5 clk = ~clk;

    exact_match_lookup #(.ADDR_W(8), .MAX_PROBE(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_key_i(req_key_i), .req_ready_o(req_ready_o),
        .hash_start_o(hash_start_o), .hash_key_o(hash_key_o),
        .hash_ready_i(hash_ready_i), .hash_val_i(hash_val_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_value_o(resp_value_o), .resp_probes_o(resp_probes_o)
    );

    logic [96:0] tbl [0:255];
    logic [7:0]  reads [$];

    always @(posedge clk) begin
        if (mem_rd_o) begin
            mem_data_i <= tbl[mem_addr_o];
            reads.push_back(mem_addr_o);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [63:0] key, input logic [31:0] hval,
                          input int stale, input int bp,
                          output logic hit, output logic [31:0] val,
                          output logic [3:0] pr, output int lat);
        reads.delete();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = key;
        check("req_ready_idle", req_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("hash_start_rise", hash_start_o, 1);
        check("hash_key", hash_key_o, key);
        hash_val_i = 32'h0000_0050;
        for (int i = 0; i < stale; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stale_no_read", mem_rd_o, 0);
            check("stale_start_held", hash_start_o, 1);
        end
        hash_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        hash_val_i   = hval;
        hash_ready_i = 1'b1;
        resp_ready_i = (bp == 0);
        lat = 0;
        while (lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid_o) break;
        end
        check("resp_seen", resp_valid_o, 1);
        check("hash_start_dropped", hash_start_o, 0);
        hit = resp_hit_o;
        val = resp_value_o;
        pr  = resp_probes_o;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", resp_valid_o, 1);
            check("bp_hit", resp_hit_o, hit);
            check("bp_value", resp_value_o, val);
            check("bp_probes", resp_probes_o, pr);
            check("bp_req_ready", req_ready_o, 0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("resp_done", resp_valid_o, 0);
        check("req_ready_back", req_ready_o, 1);
    endtask

    task automatic check_reads(input logic [7:0] first, input int n);
        logic [7:0] a;
        check("read_count", reads.size(), n);
        a = first;
        for (int i = 0; i < n && i < reads.size(); i++) begin
            check("read_addr", reads[i], a);
            a = a + 8'd1;
        end
    endtask

    logic [63:0] k1, k2, k3, k4, k5;
    logic        hit;
    logic [31:0] val;
    logic [3:0]  pr;
    int          lat;
    int          pulses;

    initial begin
        k1 = 64'h0102_0304_0506_0708;
        k2 = 64'h1111_2222_3333_4444;
        k3 = 64'h3333_0000_3333_0000;
        k4 = 64'h4444_4444_0000_0001;
        k5 = 64'h5555_6666_7777_8888;
        for (int i = 0; i < 256; i++) tbl[i] = '0;
        tbl[8'h24] = {1'b1, k1, 32'hDEAD_BEEF};
        tbl[8'hFF] = {1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 32'h1};
        tbl[8'h00] = {1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 32'h2};
        tbl[8'h01] = {1'b1, k2, 32'h0000_1234};
        tbl[8'h10] = {1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 32'h5};
        tbl[8'h60] = {1'b1, k5, 32'hCAFE_F00D};

        rst = 1'b1; req_valid_i = 1'b0; req_key_i = '0; hash_ready_i = 1'b0;
        hash_val_i = '0; resp_ready_i = 1'b0; mem_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_hash_start", hash_start_o, 0);
        check("rst_mem_rd", mem_rd_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_hash_key", hash_key_o, 0);
        rst = 1'b0;

        lookup(k1, 32'hABCD_0024, 0, 0, hit, val, pr, lat);
        check("home_hit", hit, 1);
        check("home_value", val, 32'hDEAD_BEEF);
        check("home_probes", pr, 1);
        check("home_latency", lat, 3);
        check_reads(8'h24, 1);

        lookup(k2, 32'h5A5A_00FF, 0, 0, hit, val, pr, lat);
        check("wrap_hit", hit, 1);
        check("wrap_value", val, 32'h0000_1234);
        check("wrap_probes", pr, 3);
        check("wrap_latency", lat, 7);
        check_reads(8'hFF, 3);

        lookup(k3, 32'h0000_0010, 0, 0, hit, val, pr, lat);
        check("empty_hit", hit, 0);
        check("empty_value", val, 0);
        check("empty_probes", pr, 2);
        check("empty_latency", lat, 5);
        check_reads(8'h10, 2);

        for (int i = 0; i < 4; i++) tbl[8'h20 + i] = {1'b1, 64'hD000 + 64'(i), 32'h9};
        tbl[8'h24] = {1'b1, k4, 32'h0000_0077};
        lookup(k4, 32'h0000_0020, 0, 0, hit, val, pr, lat);
        check("exhaust_hit", hit, 0);
        check("exhaust_value", val, 0);
        check("exhaust_probes", pr, 4);
        check("exhaust_latency", lat, 9);
        check_reads(8'h20, 4);

        check("stale_ready_high", hash_ready_i, 1);
        lookup(k5, 32'h0000_0060, 3, 5, hit, val, pr, lat);
        check("stale_hit", hit, 1);
        check("stale_value", val, 32'hCAFE_F00D);
        check("stale_probes", pr, 1);
        check_reads(8'h60, 1);

        // Reset raised while start is high must mask it in the same cycle.
        @(negedge clk);
        req_valid_i = 1'b1; req_key_i = k5;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("arm_start_high", hash_start_o, 1);
        rst = 1'b1;
        #1;
        check("rst_start_same_cycle", hash_start_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset during CMP.
        reads.delete();
        req_valid_i = 1'b1; req_key_i = k5; hash_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        hash_val_i = 32'h0000_0060; hash_ready_i = 1'b1; resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_issue_rd", mem_rd_o, 1);
        @(posedge clk);
        @(negedge clk);
        check("abort_cmp_rd", mem_rd_o, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", req_ready_o, 1);
        check("abort_resp_valid", resp_valid_o, 0);
        check("abort_hash_start", hash_start_o, 0);
        check("abort_resp_hit", resp_hit_o, 0);
        check("abort_resp_value", resp_value_o, 0);
        check("abort_resp_probes", resp_probes_o, 0);
        check("abort_hash_key", hash_key_o, 0);
        check("abort_mem_addr", mem_addr_o, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid_o) pulses++;
        end
        resp_ready_i = 1'b0;
        check("abort_no_resp", pulses, 0);

        lookup(k5, 32'h0000_0060, 0, 0, hit, val, pr, lat);
        check("post_rst_hit", hit, 1);
        check("post_rst_value", val, 32'hCAFE_F00D);
        check("post_rst_probes", pr, 1);
        check("post_rst_latency", lat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
